// File: rtl/ascon_pack.sv
`timescale 1ns/1ps
// ascon_pack: shared Ascon types and constants.
//   type_state       : five 64-bit words x0..x4 (index 0 = x0)
//   SBOX_COLS        : number of 5-bit columns in a state
//   type_inv_sub_fsm : control states of the inverse substitution layer
package ascon_pack;
  localparam int SBOX_COLS = 64;
  typedef logic [4:0][SBOX_COLS-1:0] type_state;
  typedef enum logic [1:0] {IDLE, PROCESS, DONE} type_inv_sub_fsm;
endpackage

// File: rtl/inv_substitution_layer_sbox_inv.sv
`timescale 1ns/1ps
// sbox_inv: combinational inverse Ascon 5-bit S-box.
//   x : column {x0,x1,x2,x3,x4}, x0 as MSB
//   y : inverse-substituted column
// ascon_sbox (forward S-box, same port meaning) is only built with INV_SUBSTITUTION_CHECK_EN.
module sbox_inv (
  input  logic [4:0] x,
  output logic [4:0] y
);
  localparam logic [4:0] LUT [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02};
  assign y = LUT[x];
endmodule

`ifdef INV_SUBSTITUTION_CHECK_EN
module ascon_sbox (
  input  logic [4:0] x,
  output logic [4:0] y
);
  localparam logic [4:0] LUT [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  assign y = LUT[x];
endmodule
`endif

// File: rtl/inv_substitution_layer.sv
`timescale 1ns/1ps
// inv_substitution_layer: iterative inverse Ascon substitution layer, COLS_PER_CYCLE columns per clock.
//   clock_i, resetb_i    : clock (rising edge), asynchronous active-low reset
//   valid_i/ready_o      : input handshake, state_i sampled on the accept edge
//   valid_o/ready_i      : output handshake, state_o held stable while valid_o=1
//   mismatch_o           : sticky self-check error, built only with INV_SUBSTITUTION_CHECK_EN (else 0)
module inv_substitution_layer
  import ascon_pack::*;
#(
  parameter int COLS_PER_CYCLE = 8
) (
  input  logic      clock_i,
  input  logic      resetb_i,
  input  logic      valid_i,
  output logic      ready_o,
  input  type_state state_i,
  output logic      valid_o,
  input  logic      ready_i,
  output type_state state_o,
  output logic      mismatch_o
);
  localparam int N  = SBOX_COLS / COLS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;
  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4 || COLS_PER_CYCLE == 8 ||
        COLS_PER_CYCLE == 16 || COLS_PER_CYCLE == 32 || COLS_PER_CYCLE == 64)) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be one of 1, 2, 4, 8, 16, 32, 64");
  end
  type_inv_sub_fsm fsm;
  logic [CW-1:0] cnt;
  type_state st;
  logic [4:0][COLS_PER_CYCLE-1:0] cur, res;
  logic accept;
  assign accept  = fsm == IDLE && valid_i && ready_o;
  assign state_o = st;
  for (genvar w = 0; w < 5; w++) begin : g_word
    assign cur[w] = st[w][cnt * COLS_PER_CYCLE +: COLS_PER_CYCLE];
  end
`ifdef INV_SUBSTITUTION_CHECK_EN
  type_state shadow;
  logic [COLS_PER_CYCLE-1:0] col_bad;
`endif
  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
    logic [4:0] y;
    sbox_inv u_inv (.x({cur[0][j], cur[1][j], cur[2][j], cur[3][j], cur[4][j]}), .y(y));
    assign {res[0][j], res[1][j], res[2][j], res[3][j], res[4][j]} = y;
`ifdef INV_SUBSTITUTION_CHECK_EN
    // Forward-map the freshly inverted column and compare with the accepted input column.
    logic [4:0] f;
    localparam int B = j;
    ascon_sbox u_fwd (.x(y), .y(f));
    assign col_bad[j] = f != {shadow[0][cnt * COLS_PER_CYCLE + B], shadow[1][cnt * COLS_PER_CYCLE + B],
                              shadow[2][cnt * COLS_PER_CYCLE + B], shadow[3][cnt * COLS_PER_CYCLE + B],
                              shadow[4][cnt * COLS_PER_CYCLE + B]};
`endif
  end
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm     <= IDLE;
      cnt     <= '0;
      st      <= '0;
      valid_o <= 1'b0;
      ready_o <= 1'b1;
    end else begin
      case (fsm)
        IDLE: if (accept) begin
          st      <= state_i;
          cnt     <= '0;
          ready_o <= 1'b0;
          fsm     <= PROCESS;
        end
        PROCESS: begin
          for (int w = 0; w < 5; w++) st[w][cnt * COLS_PER_CYCLE +: COLS_PER_CYCLE] <= res[w];
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            valid_o <= 1'b1;
            fsm     <= DONE;
          end
        end
        DONE: if (ready_i) begin
          valid_o <= 1'b0;
          ready_o <= 1'b1;
          fsm     <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
`ifdef INV_SUBSTITUTION_CHECK_EN
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      shadow     <= '0;
      mismatch_o <= 1'b0;
    end else if (accept) begin
      shadow     <= state_i;
      mismatch_o <= 1'b0;
    end else if (fsm == PROCESS && |col_bad) begin
      mismatch_o <= 1'b1;
    end
  end
`else
  assign mismatch_o = 1'b0;
`endif
endmodule
